pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter stage of the 16-bit single-cycle CPU. It holds the PC register and selects the next PC: sequential (PC+2), conditional branch (PC+2 plus the already-shifted branch offset produced by the branch shift-left stage), or absolute jump. It detects misaligned targets and runs a small trap state machine. An optional return-address stack supports call/return. It consumes the shift-left stage output directly and feeds the instruction-memory address.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- TRAP_VEC, 16'h0004, PC value loaded when a trap is cleared
- RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold PC this cycle
- branch_taken  in  1  branch condition true (branch op AND ALU zero)
- branch_offset_shl  in  16  byte offset from the shift-left stage, two's complement
- jump  in  1  absolute jump request
- jump_target  in  16  absolute jump/call address
- call  in  1  call request (push PC+2, go to jump_target)
- ret  in  1  return request (pop target)
- trap_clr  in  1  acknowledge trap, resume at TRAP_VEC
- pc  out  16  current PC (registered)
- pc_plus2  out  16  pc + 2, combinational, modulo 2^16
- trap  out  1  misaligned-target or RAS-underflow trap pending (registered)
- taken_count  out  16  number of taken-branch redirects (registered)

## Operation
- States: RUN, TRAP. Reset: state=RUN, pc=RESET_PC, trap=0, taken_count=0, RAS empty.
- RUN next-PC priority, highest first: stall > ret > call > jump > branch_taken > sequential.
- stall: pc, RAS and taken_count hold; all other requests in that cycle are ignored.
- Branch target = pc + 2 + branch_offset_shl, 16-bit wrap (e.g. pc=FFFE, offset=0002 -> 0002).
- Sequential: pc <= pc_plus2; FFFE wraps to 0000.
- Selected target with bit0=1 (jump, call or branch): pc holds, state -> TRAP, trap=1; no RAS push, no count increment.
- taken_count increments only on an accepted (aligned, unstalled, highest-priority) branch redirect; wraps FFFF -> 0000.
- TRAP: pc holds, all requests except trap_clr ignored (stall included). trap_clr: pc <= TRAP_VEC, trap=0, state -> RUN. trap_clr in RUN is ignored.
- Simultaneous call and ret: ret wins; call is dropped.

## Timing
- pc, trap, taken_count update on the rising clk edge after the controlling inputs are sampled: one-cycle redirect latency, no bubbles.
- pc_plus2 and the branch target are purely combinational from pc and inputs.
- trap asserts the edge after a misaligned target is selected; pc shows TRAP_VEC the edge after trap_clr is sampled.
- rst_n low overrides everything, including mid-TRAP and mid-stall; RAS contents are discarded.

## Configuration
- PC_RAS_EN defined: RAS_DEPTH-entry return-address stack. call pushes pc_plus2 and jumps to jump_target. ret pops into pc. Push when full overwrites the oldest entry (circular). Pop when empty -> TRAP.
- PC_RAS_EN undefined: no stack storage; call behaves exactly as jump (no push); ret is ignored and the cycle proceeds at the next priority level.

## Structure
- Shared CPU package: pc_state_t enum (RUN, TRAP), PC_WIDTH=16, default RESET_PC/TRAP_VEC constants.
- One sub-module: pc_ras (circular stack, push/pop/full/empty), instantiated only under PC_RAS_EN.

## Test plan
- Reset with RESET_PC=0000, 3 unstalled cycles -> pc 0000, 0002, 0004, 0006; trap=0, taken_count=0.
- pc=0010, branch_taken=1, branch_offset_shl=FFF8 -> next pc=000A, taken_count=1. Same with stall=1 -> pc stays 0010, count unchanged.
- pc=0020, jump=1, jump_target=0101 -> trap=1, pc holds 0020 for 3 cycles despite requests; trap_clr=1 -> pc=0004, trap=0.
- pc=FFFE sequential -> 0000. taken_count at FFFF plus one taken branch -> 0000.
- PC_RAS_EN: pc=0040 call target 0200 -> pc=0200; ret -> 0042. Five nested calls with depth 4, then five rets -> last ret traps.
- PC_RAS_EN undefined: call target 0200 -> pc=0200; ret at 0200 -> pc=0202.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared CPU definitions for the program-counter stage: widths, default vectors,
// the RUN/TRAP state type and the target-alignment helper.
package pc_branch_unit_pkg;

  localparam int PC_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [PC_WIDTH-1:0] DEFAULT_TRAP_VEC = 16'h0004;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_t;

  // Instructions are 16-bit, so any target with bit 0 set cannot be fetched.
  function automatic logic misaligned(input logic [PC_WIDTH-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/pc_branch_unit_ras.sv
// Circular return-address stack. A push onto a full stack silently overwrites
// the oldest entry, so only the newest DEPTH return addresses survive.
module pc_ras
  import pc_branch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top_data,
  output logic                full,
  output logic                empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PC_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    ptr;
  logic [CNT_W-1:0]    count;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign top_data = mem[ptr - PTR_ONE];

  // ptr always names the next free slot; the occupancy count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register and next-PC selection with misaligned-target trap handling.
// Define PC_RAS_EN to add the return-address stack for call/ret.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC  = DEFAULT_TRAP_VEC,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset_shl,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  input  logic                trap_clr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus2,
  output logic                trap,
  output logic [15:0]         taken_count
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_TRAP = TRAP;

  logic [0:0]          state;
  logic [0:0]          next_state;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] branch_target;
  logic                count_inc;
  logic                ras_push;
  logic                ras_pop;
  logic                ras_empty;
  logic [PC_WIDTH-1:0] ras_top;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
  logic unused_ras_full;

  pc_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus2),
    .top_data (ras_top),
    .full     (unused_ras_full),
    .empty    (ras_empty)
  );
`else
  localparam bit RAS_EN = 1'b0;
  logic unused_ras;

  assign ras_empty  = 1'b1;
  assign ras_top    = '0;
  assign unused_ras = ^{ras_push, ras_pop, 32'(RAS_DEPTH)};
`endif

  assign pc_plus2      = pc + 16'd2;
  assign branch_target = pc_plus2 + branch_offset_shl;
  assign trap          = (state == ST_TRAP);

  // Priority: stall > ret > call > jump > branch > sequential. A misaligned
  // pick parks the PC and traps without pushing or counting.
  always_comb begin
    next_pc    = pc;
    next_state = state;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    count_inc  = 1'b0;
    if (state == ST_TRAP) begin
      if (trap_clr) begin
        next_pc    = TRAP_VEC;
        next_state = ST_RUN;
      end
    end else if (!stall) begin
      if (RAS_EN && ret) begin
        if (ras_empty) begin
          next_state = ST_TRAP;
        end else begin
          next_pc = ras_top;
          ras_pop = 1'b1;
        end
      end else if (call || jump) begin
        if (misaligned(jump_target)) begin
          next_state = ST_TRAP;
        end else begin
          next_pc  = jump_target;
          ras_push = RAS_EN && call;
        end
      end else if (branch_taken) begin
        if (misaligned(branch_target)) begin
          next_state = ST_TRAP;
        end else begin
          next_pc   = branch_target;
          count_inc = 1'b1;
        end
      end else begin
        next_pc = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      taken_count <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (count_inc) taken_count <= taken_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized
// traffic against a queue-based reference model. Honors PC_RAS_EN.
module tb_pc_branch_unit;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] TRAP_VEC  = 16'h0004;
  localparam int          RAS_DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, jump, call, ret, trap_clr;
  logic [15:0] branch_offset_shl, jump_target;
  logic [15:0] pc, pc_plus2, taken_count;
  logic        trap;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] m_pc;
  logic        m_trap;
  logic [15:0] m_count;
  logic [15:0] m_stack[$];

  always #5 clk = ~clk;

  pc_branch_unit #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_offset_shl(branch_offset_shl),
    .jump             (jump),
    .jump_target      (jump_target),
    .call             (call),
    .ret              (ret),
    .trap_clr         (trap_clr),
    .pc               (pc),
    .pc_plus2         (pc_plus2),
    .trap             (trap),
    .taken_count      (taken_count)
  );

  // Reference behaviour: straight from the next-PC rules, stack as a queue.
  task automatic model_step();
    logic [15:0] p2, tgt;
    p2  = m_pc + 16'd2;
    tgt = p2 + branch_offset_shl;
    if (!rst_n) begin
      m_pc = RESET_PC; m_trap = 1'b0; m_count = 16'd0; m_stack.delete();
    end else if (m_trap) begin
      if (trap_clr) begin m_pc = TRAP_VEC; m_trap = 1'b0; end
    end else if (stall) begin
      m_pc = m_pc;
    end else if (RAS && ret) begin
      if (m_stack.size() == 0) m_trap = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (call || jump) begin
      if (jump_target[0]) m_trap = 1'b1;
      else begin
        if (RAS && call) begin
          m_stack.push_back(p2);
          if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
        end
        m_pc = jump_target;
      end
    end else if (branch_taken) begin
      if (tgt[0]) m_trap = 1'b1;
      else begin m_pc = tgt; m_count = m_count + 16'd1; end
    end else begin
      m_pc = p2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; trap_clr = 0;
    branch_offset_shl = 16'h0000; jump_target = 16'h0000;
  endtask

  task automatic go_to(input logic [15:0] addr);
    idle(); jump = 1; jump_target = addr; tick(); idle();
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc;
    idle(); rst_n = 0; tick(); tick();
    compared++; if (pc !== RESET_PC) begin mismatched++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    compared++; if (trap !== 1'b0) begin mismatched++; $display("FAIL reset_trap: got %b want 0", trap); end
    compared++; if (taken_count !== 16'h0) begin mismatched++; $display("FAIL reset_count: got %h want 0000", taken_count); end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 16'(2 * i);
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc); end
    end
  endtask

  task automatic test_branch_stall();
    logic [15:0] base;
    go_to(16'h0010);
    base = m_count;
    stall = 1; branch_taken = 1; branch_offset_shl = 16'hFFF8; tick();
    compared++; if (pc !== 16'h0010) begin mismatched++; $display("FAIL stall_pc: got %h want 0010", pc); end
    compared++; if (taken_count !== base) begin mismatched++; $display("FAIL stall_count: got %h want %h", taken_count, base); end
    stall = 0; tick(); idle();
    compared++; if (pc !== 16'h000A) begin mismatched++; $display("FAIL branch_pc: got %h want 000A", pc); end
    compared++; if (taken_count !== base + 16'd1) begin mismatched++; $display("FAIL branch_count: got %h want %h", taken_count, base + 16'd1); end
  endtask

  task automatic test_jump_trap();
    go_to(16'h0020);
    jump = 1; jump_target = 16'h0101; tick();
    compared++; if (trap !== 1'b1) begin mismatched++; $display("FAIL trap_set: got %b want 1", trap); end
    compared++; if (pc !== 16'h0020) begin mismatched++; $display("FAIL trap_pc: got %h want 0020", pc); end
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1); jump = 1; jump_target = 16'h0300; branch_taken = 1; call = 1; ret = 1; tick();
      compared++; if (pc !== 16'h0020 || trap !== 1'b1) begin mismatched++; $display("FAIL trap_hold%0d: got %h/%b want 0020/1", i, pc, trap); end
    end
    idle(); trap_clr = 1; tick(); idle();
    compared++; if (pc !== TRAP_VEC || trap !== 1'b0) begin mismatched++; $display("FAIL trap_clr: got %h/%b want %h/0", pc, trap, TRAP_VEC); end
    trap_clr = 1; tick(); idle();
    compared++; if (pc !== TRAP_VEC + 16'd2) begin mismatched++; $display("FAIL clr_in_run: got %h want %h", pc, TRAP_VEC + 16'd2); end
    branch_taken = 1; branch_offset_shl = 16'h0003; tick(); idle();
    compared++; if (trap !== 1'b1 || taken_count !== m_count) begin mismatched++; $display("FAIL branch_misalign: got %b/%h want 1/%h", trap, taken_count, m_count); end
    trap_clr = 1; tick(); idle();
  endtask

  task automatic test_wrap();
    go_to(16'hFFFE); tick();
    compared++; if (pc !== 16'h0000) begin mismatched++; $display("FAIL pc_wrap: got %h want 0000", pc); end
    go_to(16'hFFFE);
    branch_taken = 1; branch_offset_shl = 16'h0002; tick(); idle();
    compared++; if (pc !== 16'h0002) begin mismatched++; $display("FAIL target_wrap: got %h want 0002", pc); end
  endtask

  task automatic test_count_wrap();
    idle(); rst_n = 0; tick(); rst_n = 1;
    branch_taken = 1; branch_offset_shl = 16'h0000;
    for (int i = 0; i < 65535; i++) tick();
    compared++; if (taken_count !== 16'hFFFF) begin mismatched++; $display("FAIL count_ffff: got %h want FFFF", taken_count); end
    tick(); idle();
    compared++; if (taken_count !== 16'h0000) begin mismatched++; $display("FAIL count_wrap: got %h want 0000", taken_count); end
  endtask

  task automatic test_call_ret();
    idle(); rst_n = 0; tick(); rst_n = 1;
    go_to(16'h0040);
    call = 1; jump_target = 16'h0200; tick(); idle();
    compared++; if (pc !== 16'h0200) begin mismatched++; $display("FAIL call_pc: got %h want 0200", pc); end
    ret = 1; tick(); idle();
`ifdef PC_RAS_EN
    compared++; if (pc !== 16'h0042) begin mismatched++; $display("FAIL ret_pc: got %h want 0042", pc); end
    go_to(16'h1000);
    for (int i = 1; i <= 5; i++) begin
      call = 1; jump_target = 16'(i * 16'h0100); tick(); idle();
    end
    for (int i = 4; i >= 1; i--) begin
      ret = 1; tick(); idle();
      compared++; if (pc !== 16'(i * 16'h0100 + 2)) begin mismatched++; $display("FAIL nested_ret%0d: got %h want %h", i, pc, 16'(i * 16'h0100 + 2)); end
    end
    ret = 1; tick(); idle();
    compared++; if (trap !== 1'b1 || pc !== 16'h0102) begin mismatched++; $display("FAIL underflow: got %b/%h want 1/0102", trap, pc); end
    trap_clr = 1; tick(); idle();
`else
    compared++; if (pc !== 16'h0202) begin mismatched++; $display("FAIL ret_ignored: got %h want 0202", pc); end
`endif
  endtask

  task automatic test_random();
    idle(); rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(63) != 0);
      stall        = ($urandom_range(7) == 0);
      ret          = ($urandom_range(5) == 0);
      call         = ($urandom_range(5) == 0);
      jump         = ($urandom_range(7) == 0);
      branch_taken = ($urandom_range(3) == 0);
      trap_clr     = ($urandom_range(3) == 0);
      jump_target  = 16'($urandom) & (($urandom_range(7) == 0) ? 16'hFFFF : 16'hFFFE);
      branch_offset_shl = 16'($urandom) & (($urandom_range(7) == 0) ? 16'hFFFF : 16'hFFFE);
      tick();
      compared++;
      if (pc !== m_pc || trap !== m_trap || taken_count !== m_count || pc_plus2 !== m_pc + 16'd2) begin
        mismatched++;
        $display("FAIL random%0d: got pc=%h trap=%b cnt=%h p2=%h want pc=%h trap=%b cnt=%h p2=%h",
                 i, pc, trap, taken_count, pc_plus2, m_pc, m_trap, m_count, m_pc + 16'd2);
      end
    end
    idle(); rst_n = 1;
  endtask

  initial begin
    idle(); rst_n = 0;
    m_pc = 16'hxxxx; m_trap = 1'b0; m_count = 16'd0;
    test_reset();
    test_branch_stall();
    test_jump_trap();
    test_wrap();
    test_call_ret();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
